// File: rtl/memory_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_pkg
//  Description : Shared types and constants for the memory-access stage:
//                FSM state encoding, access-size codes, CBNZ opcode prefix
//                and small decode helpers for byte masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_access_pkg;

    localparam int C_WORD  = 64;
    localparam int C_BYTES = 8;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_CHECK = 2'd1,
        MA_REQ   = 2'd2,
        MA_DONE  = 2'd3
    } ma_state_t;

    // opcode[10:9] encodes log2 of the access size in bytes
    localparam logic [1:0] C_SIZE_B = 2'd0;
    localparam logic [1:0] C_SIZE_H = 2'd1;
    localparam logic [1:0] C_SIZE_W = 2'd2;
    localparam logic [1:0] C_SIZE_D = 2'd3;

    localparam logic [7:0] C_CBNZ_PREFIX = 8'hB5;

    // Low-address bits that must be zero for an access of this size
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [2:0] m;
        unique case (size)
            C_SIZE_B: m = 3'b000;
            C_SIZE_H: m = 3'b001;
            C_SIZE_W: m = 3'b011;
            default:  m = 3'b111;
        endcase
        return m;
    endfunction

    // Byte enables for an access of this size starting at lane 0
    function automatic logic [C_BYTES-1:0] lane_enables(input logic [1:0] size);
        logic [C_BYTES-1:0] e;
        unique case (size)
            C_SIZE_B: e = 8'h01;
            C_SIZE_H: e = 8'h03;
            C_SIZE_W: e = 8'h0F;
            default:  e = 8'hFF;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_load_align
//  Description : Combinational load aligner. Shifts the addressed byte lane
//                of a read doubleword down to bit 0, keeps 'size' bytes and
//                zero- or sign-extends the result to a full word.
//  Ports       : i_rdata    - read doubleword from the bus
//                i_offset   - byte offset within the doubleword
//                i_size     - access size code (B/H/W/D)
//                i_sign_ext - 1 = sign-extend, 0 = zero-extend
//                o_value    - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [C_WORD-1:0] i_rdata,
    input  logic [2:0]        i_offset,
    input  logic [1:0]        i_size,
    input  logic              i_sign_ext,
    output logic [C_WORD-1:0] o_value
);

    logic [C_WORD-1:0] w_lane;

    always_comb begin
        w_lane  = i_rdata >> {i_offset, 3'b000};
        o_value = '0;
        unique case (i_size)
            C_SIZE_B: o_value = {{56{i_sign_ext & w_lane[7]}},  w_lane[7:0]};
            C_SIZE_H: o_value = {{48{i_sign_ext & w_lane[15]}}, w_lane[15:0]};
            C_SIZE_W: o_value = {{32{i_sign_ext & w_lane[31]}}, w_lane[31:0]};
            default:  o_value = w_lane;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access
//  Description : Memory stage following Execute. Latches Execute results on a
//                start pulse, checks alignment, resolves the branch decision
//                and performs one load/store on a req/ack data bus.
//  Ports       : clk, reset (sync, active-high), start
//                Execute side : opcode, alu_result, read_data2, branch_target,
//                               zero, mem_read, mem_write, branch, uncond_branch
//                Bus side     : mem_req, mem_we, mem_addr, mem_be, mem_wdata,
//                               mem_rdata, mem_ack
//                Results      : read_data, pc_src, branch_target_q, done,
//                               busy, fault
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_access
    import memory_access_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [10:0]         opcode,
    input  logic [C_WORD-1:0]   alu_result,
    input  logic [C_WORD-1:0]   read_data2,
    input  logic [C_WORD-1:0]   branch_target,
    input  logic                zero,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                branch,
    input  logic                uncond_branch,
    output logic                mem_req,
    output logic                mem_we,
    output logic [C_WORD-1:0]   mem_addr,
    output logic [C_BYTES-1:0]  mem_be,
    output logic [C_WORD-1:0]   mem_wdata,
    input  logic [C_WORD-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [C_WORD-1:0]   read_data,
    output logic                pc_src,
    output logic [C_WORD-1:0]   branch_target_q,
    output logic                done,
    output logic                busy,
    output logic                fault
);

    ma_state_t          r_state;
    ma_state_t          w_next_state;

    logic [7:0]         r_opcode_hi;      // opcode[10:3]; low bits carry no decode
    logic [C_WORD-1:0]  r_addr;
    logic [C_WORD-1:0]  r_store_data;
    logic [C_WORD-1:0]  r_branch_target;
    logic               r_zero;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_branch;
    logic               r_uncond_branch;
    logic [C_WORD-1:0]  r_read_data;
    logic               r_pc_src;
    logic               r_fault;

    logic [1:0]         w_size;
    logic [2:0]         w_offset;
    logic               w_access;
    logic               w_fault;
    logic               w_pc_src;
    logic               w_is_cbnz;
    logic [C_WORD-1:0]  w_load_value;
    logic               w_unused_opcode;

    assign w_unused_opcode = ^opcode[2:0];

    assign w_size    = r_opcode_hi[7:6];
    assign w_offset  = r_addr[2:0];
    assign w_access  = r_mem_read | r_mem_write;
    assign w_is_cbnz = (r_opcode_hi == C_CBNZ_PREFIX);
    assign w_pc_src  = r_uncond_branch | (r_branch & (r_zero ^ w_is_cbnz));
    // Alignment only matters when the bus is actually used; asking for both
    // a read and a write is always an error.
    assign w_fault   = (r_mem_read & r_mem_write)
                     | (w_access & (|(w_offset & size_mask(w_size))));

    memory_access_load_align u_load_align (
        .i_rdata    (mem_rdata),
        .i_offset   (w_offset),
        .i_size     (w_size),
        .i_sign_ext (w_size == C_SIZE_W),
        .o_value    (w_load_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MA_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_be       = '0;
        mem_wdata    = '0;
        done         = 1'b0;
        busy         = (r_state != MA_IDLE);
        unique case (r_state)
            MA_IDLE: begin
                if (start) begin
                    w_next_state = MA_CHECK;
                end
            end
            MA_CHECK: begin
                if (w_fault || !w_access) begin
                    w_next_state = MA_DONE;
                end else begin
                    w_next_state = MA_REQ;
                end
            end
            MA_REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_mem_write;
                mem_addr  = {r_addr[C_WORD-1:3], 3'b000};
                mem_be    = lane_enables(w_size) << w_offset;
                mem_wdata = r_store_data << {w_offset, 3'b000};
                if (mem_ack) begin
                    w_next_state = MA_DONE;
                end
            end
            default: begin
                done         = 1'b1;
                w_next_state = MA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode_hi     <= '0;
            r_addr          <= '0;
            r_store_data    <= '0;
            r_branch_target <= '0;
            r_zero          <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_branch        <= 1'b0;
            r_uncond_branch <= 1'b0;
            r_read_data     <= '0;
            r_pc_src        <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            if (r_state == MA_IDLE && start) begin
                r_opcode_hi     <= opcode[10:3];
                r_addr          <= alu_result;
                r_store_data    <= read_data2;
                r_branch_target <= branch_target;
                r_zero          <= zero;
                r_mem_read      <= mem_read;
                r_mem_write     <= mem_write;
                r_branch        <= branch;
                r_uncond_branch <= uncond_branch;
            end
            if (r_state == MA_CHECK) begin
                r_fault  <= w_fault;
                r_pc_src <= w_pc_src;
            end
            // Stores leave the previous load result in place
            if (r_state == MA_REQ && mem_ack && r_mem_read) begin
                r_read_data <= w_load_value;
            end
        end
    end

    assign read_data       = r_read_data;
    assign pc_src          = r_pc_src;
    assign fault           = r_fault;
    assign branch_target_q = r_branch_target;

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access
//  Description : Self-checking bench for memory_access: directed vector
//                table, reset corner sequences and randomized operations
//                compared with a byte-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] opcode = '0;
    logic [63:0] alu_result = '0;
    logic [63:0] read_data2 = '0;
    logic [63:0] branch_target = '0;
    logic        zero = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        branch = 1'b0;
    logic        uncond_branch = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [63:0] read_data;
    logic        pc_src;
    logic [63:0] branch_target_q;
    logic        done;
    logic        busy;
    logic        fault;

    int checks = 0;
    int errors = 0;

    memory_access dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .opcode          (opcode),
        .alu_result      (alu_result),
        .read_data2      (read_data2),
        .branch_target   (branch_target),
        .zero            (zero),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .branch          (branch),
        .uncond_branch   (uncond_branch),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .read_data       (read_data),
        .pc_src          (pc_src),
        .branch_target_q (branch_target_q),
        .done            (done),
        .busy            (busy),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          req_seen;
        bit          stable;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        int          lat;
        logic [63:0] rd;
        logic [63:0] btq;
        logic        pc;
        logic        fault;
        bit          busy_ok;
        bit          after_ok;
    } obs_t;

    typedef struct {
        logic [10:0] op;
        logic [63:0] addr;
        logic [63:0] rd2;
        logic [63:0] rdata;
        logic        z, rd, wr, br, ub;
        int          ack_delay;
        bit          e_req;
        logic [7:0]  e_be;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic        e_we;
        logic [63:0] e_rd;
        logic        e_pc;
        logic        e_fault;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one operation; ack arrives in the (ack_delay+1)-th request cycle.
    task automatic run_op(input logic [10:0] op, input logic [63:0] addr, rd2, btgt, rdata,
                          input logic z, rd, wr, br, ub, input int ack_delay,
                          input bit extra_start, input bit stray, output obs_t o);
        int k;
        int req_n;
        o = '{default: '0};
        o.stable  = 1'b1;
        o.busy_ok = 1'b1;
        o.lat     = -1;
        @(negedge clk);
        opcode = op; alu_result = addr; read_data2 = rd2; branch_target = btgt;
        mem_rdata = rdata; zero = z; mem_read = rd; mem_write = wr;
        branch = br; uncond_branch = ub; start = 1'b1;
        k = 0;
        req_n = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (done) begin
                o.lat = k;
                o.rd = read_data; o.pc = pc_src; o.fault = fault; o.btq = branch_target_q;
                if (!busy) o.busy_ok = 1'b0;
                mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                break;
            end
            if (!busy) o.busy_ok = 1'b0;
            if (extra_start && k == 2) begin
                // a second start while busy must be ignored
                start = 1'b1;
                alu_result = addr ^ 64'h8;
                read_data2 = ~rd2;
            end
            if (mem_req) begin
                req_n++;
                if (!o.req_seen) begin
                    o.req_seen = 1'b1;
                    o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata; o.we = mem_we;
                end else if (o.be !== mem_be || o.addr !== mem_addr ||
                             o.wdata !== mem_wdata || o.we !== mem_we) begin
                    o.stable = 1'b0;
                end
                mem_ack = (req_n - 1 == ack_delay);
            end else begin
                mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        o.after_ok = !done && !busy;
        mem_ack = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input bit e_req, input logic [7:0] e_be,
                           input logic [63:0] e_addr, e_wdata, input logic e_we,
                           input logic [63:0] e_rd, input logic e_pc, e_fault,
                           input int e_lat, input logic [63:0] e_btq);
        chk({tag, ".latency"}, 64'(o.lat), 64'(e_lat));
        chk({tag, ".mem_req_seen"}, 64'(o.req_seen), 64'(e_req));
        if (e_req) begin
            chk({tag, ".mem_be"}, 64'(o.be), 64'(e_be));
            chk({tag, ".mem_addr"}, o.addr, e_addr);
            chk({tag, ".mem_wdata"}, o.wdata, e_wdata);
            chk({tag, ".mem_we"}, 64'(o.we), 64'(e_we));
            chk({tag, ".bus_stable"}, 64'(o.stable), 64'd1);
        end
        chk({tag, ".read_data"}, o.rd, e_rd);
        chk({tag, ".pc_src"}, 64'(o.pc), 64'(e_pc));
        chk({tag, ".fault"}, 64'(o.fault), 64'(e_fault));
        chk({tag, ".branch_target_q"}, o.btq, e_btq);
        chk({tag, ".busy_through_done"}, 64'(o.busy_ok), 64'd1);
        chk({tag, ".idle_after_done"}, 64'(o.after_ok), 64'd1);
    endtask

    vec_t        tbl[12];
    obs_t        o;
    logic [63:0] m_rd;

    initial begin
        tbl[0]  = '{11'h7C2, 64'h10, 64'h0, 64'h1122334455667788, 0,1,0,0,0, 1,
                    1, 8'hFF, 64'h10, 64'h0, 0, 64'h1122334455667788, 0, 0, 4};
        tbl[1]  = '{11'h1C0, 64'h13, 64'hAB, 64'h0, 0,0,1,0,0, 0,
                    1, 8'h08, 64'h10, 64'hAB000000, 1, 64'h1122334455667788, 0, 0, 3};
        tbl[2]  = '{11'h5C4, 64'h4, 64'h0, 64'h8000000000000000, 0,1,0,0,0, 0,
                    1, 8'hF0, 64'h0, 64'h0, 0, 64'hFFFFFFFF80000000, 0, 0, 3};
        tbl[3]  = '{11'h3C2, 64'h5, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0,1,0,0,0, 0,
                    0, 8'h00, 64'h0, 64'h0, 0, 64'hFFFFFFFF80000000, 0, 1, 2};
        tbl[4]  = '{11'h5A0, 64'h0, 64'h0, 64'h0, 1,0,0,1,0, 0,
                    0, 8'h00, 64'h0, 64'h0, 0, 64'hFFFFFFFF80000000, 1, 0, 2};
        tbl[5]  = '{11'h5A8, 64'h0, 64'h0, 64'h0, 1,0,0,1,0, 0,
                    0, 8'h00, 64'h0, 64'h0, 0, 64'hFFFFFFFF80000000, 0, 0, 2};
        tbl[6]  = '{11'h0A0, 64'h0, 64'h0, 64'h0, 0,0,0,0,1, 0,
                    0, 8'h00, 64'h0, 64'h0, 0, 64'hFFFFFFFF80000000, 1, 0, 2};
        tbl[7]  = '{11'h5A8, 64'h0, 64'h0, 64'h0, 0,0,0,1,0, 0,
                    0, 8'h00, 64'h0, 64'h0, 0, 64'hFFFFFFFF80000000, 1, 0, 2};
        tbl[8]  = '{11'h1C2, 64'hF, 64'h0, 64'hAABBCCDDEEFF0011, 0,1,0,0,0, 2,
                    1, 8'h80, 64'h8, 64'h0, 0, 64'hAA, 0, 0, 5};
        tbl[9]  = '{11'h7C2, 64'h18, 64'h0, 64'h0, 0,1,1,0,0, 0,
                    0, 8'h00, 64'h0, 64'h0, 0, 64'hAA, 0, 1, 2};
        tbl[10] = '{11'h7C0, 64'h20, 64'hDEADBEEF01234567, 64'h0, 0,0,1,0,0, 0,
                    1, 8'hFF, 64'h20, 64'hDEADBEEF01234567, 1, 64'hAA, 0, 0, 3};
        tbl[11] = '{11'h3C2, 64'h6, 64'h0, 64'h8001000000000000, 0,1,0,0,0, 1,
                    1, 8'hC0, 64'h0, 64'h0, 0, 64'h8001, 0, 0, 4};

        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.mem_req", 64'(mem_req), 64'd0);
        chk("reset.mem_we", 64'(mem_we), 64'd0);
        chk("reset.mem_be", 64'(mem_be), 64'd0);
        chk("reset.read_data", read_data, 64'd0);
        chk("reset.pc_src", 64'(pc_src), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.fault", 64'(fault), 64'd0);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 12; i++) begin
            logic [63:0] btgt;
            btgt = 64'h4000 + 64'(i * 4);
            run_op(tbl[i].op, tbl[i].addr, tbl[i].rd2, btgt, tbl[i].rdata, tbl[i].z,
                   tbl[i].rd, tbl[i].wr, tbl[i].br, tbl[i].ub, tbl[i].ack_delay, 1'b0, 1'b0, o);
            compare($sformatf("vec%0d", i), o, tbl[i].e_req, tbl[i].e_be, tbl[i].e_addr,
                    tbl[i].e_wdata, tbl[i].e_we, tbl[i].e_rd, tbl[i].e_pc, tbl[i].e_fault,
                    tbl[i].e_lat, btgt);
        end

        // reset while a request is outstanding, then a late ack while idle
        @(negedge clk);
        opcode = 11'h7C2; alu_result = 64'h8; mem_read = 1'b1; mem_write = 1'b0;
        branch = 1'b0; uncond_branch = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midreq.mem_req_asserted", 64'(mem_req), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreq.mem_req_dropped", 64'(mem_req), 64'd0);
        chk("midreq.busy_dropped", 64'(busy), 64'd0);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lateack.busy", 64'(busy), 64'd0);
        chk("lateack.done", 64'(done), 64'd0);
        chk("lateack.read_data", read_data, 64'd0);
        run_op(tbl[0].op, tbl[0].addr, tbl[0].rd2, 64'h5000, tbl[0].rdata, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, o);
        compare("after_reset", o, 1'b1, 8'hFF, 64'h10, 64'h0, 1'b0,
                64'h1122334455667788, 1'b0, 1'b0, 4, 64'h5000);

        // start together with reset: reset wins
        @(negedge clk);
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("start_reset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("start_reset.busy_next", 64'(busy), 64'd0);
        chk("start_reset.read_data", read_data, 64'd0);

        // randomized operations against the reference model
        m_rd = 64'd0;
        for (int n = 0; n < 80; n++) begin
            logic [10:0] op;
            logic [63:0] addr, rd2, rdata, btgt, lv, e_wdata;
            logic        z, rd, wr, br, ub, e_fault, e_pc;
            logic [7:0]  e_be;
            int          kind, sz, off, ad;
            bit          acc, e_req;
            kind  = $urandom_range(0, 9);
            op    = 11'($urandom);
            addr  = {$urandom, $urandom};
            rd2   = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            btgt  = {$urandom, $urandom};
            z     = 1'($urandom_range(0, 1));
            rd = 1'b0; wr = 1'b0; br = 1'b0; ub = 1'b0;
            if (kind <= 3) rd = 1'b1;
            else if (kind <= 6) wr = 1'b1;
            else if (kind <= 8) begin
                br = 1'b1;
                op = {(kind == 7) ? 8'hB4 : 8'hB5, op[2:0]};
            end else if ($urandom_range(0, 1) == 1) begin
                rd = 1'b1; wr = 1'b1;
            end else begin
                ub = 1'b1;
                op = {6'b000101, op[4:0]};
            end
            sz  = 1 << op[10:9];
            acc = rd | wr;
            if (acc) begin
                if ($urandom_range(0, 1) == 1) addr = addr & ~64'(sz - 1);
            end else begin
                addr[2:0] = 3'b000;
            end
            off     = int'(addr[2:0]);
            e_fault = (rd & wr) | (acc && (addr % 64'(sz) != 0));
            e_req   = acc && !e_fault;
            e_be = '0;
            lv   = '0;
            for (int b = 0; b < sz; b++) begin
                if (off + b < 8) begin
                    e_be[off + b] = 1'b1;
                    lv[8 * b +: 8] = rdata[8 * (off + b) +: 8];
                end
            end
            if (op[10:9] == 2'b10 && lv[31]) lv[63:32] = '1;
            if (e_req && rd) m_rd = lv;
            e_wdata = rd2 << (8 * off);
            e_pc    = ub | (br & (z ^ (op[10:3] == 8'hB5)));
            ad      = $urandom_range(0, 3);
            run_op(op, addr, rd2, btgt, rdata, z, rd, wr, br, ub, ad,
                   1'($urandom_range(0, 1)), 1'b1, o);
            compare($sformatf("rand%0d", n), o, e_req, e_be, addr & ~64'h7, e_wdata, wr,
                    m_rd, e_pc, e_fault, e_req ? 3 + ad : 2, btgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
